// File: rtl/scc_4lc_pkg.sv
// SCC 4LC (71,64) code constants and helpers.
// Shared by the decoder top and its syndrome sub-module.
package scc_4lc_pkg;

  localparam int DW = 64;
  localparam int PW = 7;
  localparam int CW = 71;

  // Index j selects H row j (row 0 is the LSB row).
  localparam logic [PW-1:0][DW-1:0] SCC_H_ROW = {
    64'h144C99EE9671707D,
    64'h73AAD511DD69C843,
    64'h309BF36678E5945C,
    64'h8E2FF9B33C52CA2E,
    64'hCCF5FCD99E296517,
    64'h0A76678A5945C2F6,
    64'h551933CD2CA2E1FB
  };

  typedef struct packed {
    logic ce;
    logic ue;
  } status_t;

  function automatic logic [PW-1:0] syndrome_f(
    input logic [CW-1:0] cw
  );
    logic [PW-1:0] s;
    for (int j = 0; j < PW; j++) begin
      s[j] = ^(cw[CW-1:PW] & SCC_H_ROW[j]) ^ cw[j];
    end
    return s;
  endfunction

  function automatic logic [PW-1:0] column_f(input int i);
    logic [PW-1:0] c;
    for (int j = 0; j < PW; j++) begin
      c[j] = SCC_H_ROW[j][i];
    end
    return c;
  endfunction

endpackage

// File: rtl/scc_4lc_syndrome.sv
// Combinational syndrome / error-locator for one codeword.
// Ports: codeword in; syndrome, flip (per message bit), chk_hit out.
module scc_4lc_syndrome
  import scc_4lc_pkg::*;
(
  input  logic [CW-1:0] codeword,
  output logic [PW-1:0] syndrome,
  output logic [DW-1:0] flip,
  output logic          chk_hit
);

  always_comb begin
    syndrome = syndrome_f(codeword);
    flip     = '0;
    for (int i = 0; i < DW; i++) begin
      flip[i] = (syndrome == column_f(i));
    end
    // A one-hot syndrome points at a check bit.
    chk_hit = $onehot(syndrome);
  end

endmodule

// File: rtl/scc_4lc_decoder.sv
// Two-stage SCC 4LC (71,64) decoder with CE/UE counters.
// Ports: clk, rst, in_* / out_* valid-ready streams, cnt_clr, ce/ue_count.
module scc_4lc_decoder
  import scc_4lc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_message,
  output logic [PW-1:0]    out_syndrome,
  output logic             out_ce,
  output logic             out_ue,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_count,
  output logic [CNT_W-1:0] ue_count
);

  logic [PW-1:0] syn;
  logic [DW-1:0] flip;
  logic          chk_hit;

  logic          s1_valid;
  logic [DW-1:0] s1_msg;
  logic [PW-1:0] s1_syn;
  logic [DW-1:0] s1_flip;
  logic          s1_chk_hit;

  logic          s2_ready;
  logic [DW-1:0] s2_msg;
  status_t       s2_st;
  status_t       out_st;
  logic          out_hs;

  scc_4lc_syndrome u_syn (
    .codeword (in_codeword),
    .syndrome (syn),
    .flip     (flip),
    .chk_hit  (chk_hit)
  );

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign out_hs   = out_valid && out_ready;
  assign out_ce   = out_st.ce;
  assign out_ue   = out_st.ue;

  always_comb begin
    s2_msg = s1_msg;
    s2_st  = '0;
    if (s1_syn == '0) begin
      s2_msg = s1_msg;
    end else if (|s1_flip) begin
      s2_msg   = s1_msg ^ s1_flip;
      s2_st.ce = 1'b1;
    end else if (s1_chk_hit) begin
      s2_st.ce = 1'b1;
    end else begin
      s2_st.ue = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_msg     <= '0;
      s1_syn     <= '0;
      s1_flip    <= '0;
      s1_chk_hit <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_msg     <= in_codeword[CW-1:PW];
        s1_syn     <= syn;
        s1_flip    <= flip;
        s1_chk_hit <= chk_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_message  <= '0;
      out_syndrome <= '0;
      out_st       <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_message  <= s2_msg;
        out_syndrome <= s1_syn;
        out_st       <= s2_st;
      end
    end
  end

  // Clear wins over a same-cycle handshake; counts saturate.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (out_hs) begin
      if (out_st.ce && ce_count != '1) begin
        ce_count <= ce_count + 1'b1;
      end
      if (out_st.ue && ue_count != '1) begin
        ue_count <= ue_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scc_4lc_decoder.sv
// Randomized self-checking bench for scc_4lc_decoder.
// Reference model: column-sum syndrome, queue scoreboard, counters.
module tb_scc_4lc_decoder;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [70:0]   in_codeword;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_message;
  logic [6:0]    out_syndrome;
  logic          out_ce;
  logic          out_ue;
  logic          cnt_clr;
  logic [15:0]   ce_count;
  logic [15:0]   ue_count;

  scc_4lc_decoder #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_codeword  (in_codeword),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_message  (out_message),
    .out_syndrome (out_syndrome),
    .out_ce       (out_ce),
    .out_ue       (out_ue),
    .cnt_clr      (cnt_clr),
    .ce_count     (ce_count),
    .ue_count     (ue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] msg;
    logic [6:0]  syn;
    logic        ce;
    logic        ue;
    int          acc;
  } exp_t;

  logic [63:0] h [7];
  exp_t        q [$];
  logic [15:0] ce_m;
  logic [15:0] ue_m;
  int          cyc;
  int          checks;
  int          errors;
  logic        stalled_prev;
  logic [79:0] prev_out;
  logic        dir_on;
  logic        dir_seen;
  logic [6:0]  dir_syn;
  logic        dir_ce;
  logic        dir_ue;

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] col(input int i);
    logic [6:0] c;
    for (int j = 0; j < 7; j++) c[j] = h[j][i];
    return c;
  endfunction

  function automatic logic [6:0] syn_m(input logic [70:0] cw);
    logic [6:0] s;
    s = cw[6:0];
    for (int i = 0; i < 64; i++) if (cw[7+i]) s ^= col(i);
    return s;
  endfunction

  function automatic exp_t model(input logic [70:0] cw);
    exp_t e;
    logic hit;
    e.msg = cw[70:7];
    e.syn = syn_m(cw);
    e.ce  = 1'b0;
    e.ue  = 1'b0;
    e.acc = 0;
    hit   = 1'b0;
    if (e.syn != 7'h00) begin
      for (int i = 0; i < 64; i++) begin
        if (col(i) == e.syn) begin
          e.msg[i] = ~e.msg[i];
          hit = 1'b1;
        end
      end
      if (hit || $countones(e.syn) == 1) e.ce = 1'b1;
      else e.ue = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [70:0] gen(input int kind);
    logic [70:0] cw;
    int a;
    int b;
    cw = {$urandom, $urandom, 7'h00};
    cw[6:0] = syn_m(cw);
    case (kind)
      1: begin a = 7 + int'($urandom % 64); cw[a] = ~cw[a]; end
      2: begin a = int'($urandom % 7); cw[a] = ~cw[a]; end
      3: begin
        a = int'($urandom % 71);
        b = (a + 1 + int'($urandom % 70)) % 71;
        cw[a] = ~cw[a];
        cw[b] = ~cw[b];
      end
      default: ;
    endcase
    return cw;
  endfunction

  task automatic run_cycle(input logic v, input logic [70:0] cw,
                           input logic rdy, input logic clr,
                           output logic hs);
    logic exp_ov;
    logic exp_ir;
    logic out_hs;
    exp_t e;
    @(negedge clk);
    cyc++;
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
    check("out_valid", out_valid, exp_ov);
    if (exp_ov && out_valid) begin
      check("out_message", out_message, q[0].msg);
      check("out_syndrome", out_syndrome, q[0].syn);
      check("out_ce", out_ce, q[0].ce);
      check("out_ue", out_ue, q[0].ue);
      if (dir_on) begin
        check("dir_syndrome", out_syndrome, dir_syn);
        check("dir_ce", out_ce, dir_ce);
        check("dir_ue", out_ue, dir_ue);
        dir_on   = 1'b0;
        dir_seen = 1'b1;
      end
    end
    if (stalled_prev) begin
      check("hold", {out_message, out_syndrome, out_ce, out_ue}, prev_out);
    end
    check("ce_count", ce_count, ce_m);
    check("ue_count", ue_count, ue_m);
    in_valid    = v;
    in_codeword = cw;
    out_ready   = rdy;
    cnt_clr     = clr;
    #1;
    exp_ir = (q.size() < 2) || rdy;
    check("in_ready", in_ready, exp_ir);
    hs     = v && exp_ir;
    out_hs = rdy && exp_ov;
    if (clr) begin
      ce_m = 16'h0;
      ue_m = 16'h0;
    end else if (out_hs) begin
      if (q[0].ce && ce_m != 16'hFFFF) ce_m++;
      if (q[0].ue && ue_m != 16'hFFFF) ue_m++;
    end
    stalled_prev = exp_ov && !rdy;
    prev_out = {out_message, out_syndrome, out_ce, out_ue};
    if (out_hs) void'(q.pop_front());
    if (hs) begin
      e = model(cw);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ce_count", ce_count, 16'h0);
    check("rst_ue_count", ue_count, 16'h0);
    check("rst_message", out_message, 64'h0);
    check("rst_status", {out_syndrome, out_ce, out_ue}, 9'h0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    q.delete();
    ce_m = 16'h0;
    ue_m = 16'h0;
    stalled_prev = 1'b0;
  endtask

  task automatic send_dir(input logic [70:0] cw, input logic [6:0] s,
                          input logic ce, input logic ue);
    logic hs;
    dir_on   = 1'b1;
    dir_seen = 1'b0;
    dir_syn  = s;
    dir_ce   = ce;
    dir_ue   = ue;
    run_cycle(1'b1, cw, 1'b1, 1'b0, hs);
    repeat (4) run_cycle(1'b0, '0, 1'b1, 1'b0, hs);
    check("dir_delivered", dir_seen, 1'b1);
    dir_on = 1'b0;
  endtask

  task automatic drain();
    logic hs;
    repeat (4) run_cycle(1'b0, '0, 1'b1, 1'b0, hs);
  endtask

  initial begin
    logic        hs;
    logic [70:0] cw;
    logic [70:0] words [10];
    logic [6:0]  s;
    logic        found;
    logic        match;
    int          ua;
    int          ub;
    int          n;
    int          k;

    h[6] = 64'h144C99EE9671707D;
    h[5] = 64'h73AAD511DD69C843;
    h[4] = 64'h309BF36678E5945C;
    h[3] = 64'h8E2FF9B33C52CA2E;
    h[2] = 64'hCCF5FCD99E296517;
    h[1] = 64'h0A76678A5945C2F6;
    h[0] = 64'h551933CD2CA2E1FB;
    checks = 0;
    errors = 0;
    cyc = 0;
    dir_on = 1'b0;
    dir_seen = 1'b0;
    dir_syn = '0;
    dir_ce = 1'b0;
    dir_ue = 1'b0;
    stalled_prev = 1'b0;
    prev_out = '0;
    ce_m = '0;
    ue_m = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_codeword = '0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;

    do_reset(3);

    send_dir(71'h0, 7'h00, 1'b0, 1'b0);
    cw = 71'h0; cw[7] = 1'b1;
    send_dir(cw, 7'h65, 1'b1, 1'b0);
    check("ce_count_one", ce_count, 16'h1);
    cw = 71'h0; cw[0] = 1'b1;
    send_dir(cw, 7'h01, 1'b1, 1'b0);
    cw = 71'h0; cw[8] = 1'b1;
    send_dir(cw, 7'h2F, 1'b1, 1'b0);

    found = 1'b0;
    ua = 0;
    ub = 1;
    for (int i = 0; i < 64 && !found; i++) begin
      for (int j = i + 1; j < 64 && !found; j++) begin
        s = col(i) ^ col(j);
        match = 1'b0;
        for (int c = 0; c < 64; c++) if (col(c) == s) match = 1'b1;
        if (!match && $countones(s) > 1) begin
          found = 1'b1;
          ua = i;
          ub = j;
        end
      end
    end
    cw = 71'h0;
    cw[7+ua] = 1'b1;
    cw[7+ub] = 1'b1;
    send_dir(cw, col(ua) ^ col(ub), 1'b0, 1'b1);
    check("ue_count_one", ue_count, 16'h1);
    check("ce_count_three", ce_count, 16'h3);

    for (int i = 0; i < 10; i++) words[i] = gen(i % 4);
    n = 0;
    k = 0;
    while (n < 10 && k < 100) begin
      run_cycle(1'b1, words[n], (k % 2) == 0, 1'b0, hs);
      if (hs) n++;
      k++;
    end
    check("bp_accepted", n, 10);
    drain();
    check("bp_empty", q.size(), 0);

    for (int i = 0; i < 3000; i++) begin
      run_cycle(($urandom % 4) != 0, gen(int'($urandom % 4)),
                ($urandom % 3) != 0, ($urandom % 60) == 0, hs);
    end
    drain();

    for (int i = 0; i < 65540; i++) begin
      run_cycle(1'b1, gen(1 + int'($urandom % 2)), 1'b1, 1'b0, hs);
    end
    drain();
    check("ce_saturated", ce_count, 16'hFFFF);

    run_cycle(1'b1, gen(1), 1'b0, 1'b0, hs);
    run_cycle(1'b0, '0, 1'b0, 1'b0, hs);
    run_cycle(1'b0, '0, 1'b1, 1'b1, hs);
    run_cycle(1'b0, '0, 1'b1, 1'b0, hs);
    check("clr_priority", ce_count, 16'h0);

    for (int i = 0; i < 3; i++) run_cycle(1'b1, gen(1), 1'b1, 1'b0, hs);
    drain();
    run_cycle(1'b1, gen(1), 1'b0, 1'b0, hs);
    run_cycle(1'b1, gen(3), 1'b0, 1'b0, hs);
    do_reset(1);
    drain();
    check("post_rst_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
